// File: rtl/lsm_sequencer.sv
// Register-list sequencer for ARM LDM/STM: walks the register list lowest-index
// first and reports progress to the microprogrammed control unit.
module lsm_sequencer #(
  parameter int NREGS  = 16,
  parameter int RIDX_W = 4,
  parameter int CNT_W  = 5
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                LSM_EN,
  input  logic [2:0]          LSM_IN,
  input  logic [NREGS-1:0]    REG_LIST,
  output logic                LSM_DETECT,
  output logic                LSM_END,
  output logic [RIDX_W-1:0]   REG_NUM,
  output logic [CNT_W-1:0]    IDX,
  output logic [CNT_W+1:0]    BEAT_OFF,
  output logic [CNT_W+1:0]    WB_OFF
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2
  } state_t;

  localparam logic [2:0] CMD_LOAD  = 3'b001;
  localparam logic [2:0] CMD_NEXT  = 3'b010;
  localparam logic [2:0] CMD_ABORT = 3'b011;

  state_t               state_q, state_d;
  logic [NREGS-1:0]     list_q, list_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CNT_W-1:0]     idx_q, idx_d;
  logic [RIDX_W-1:0]    regnum_q, regnum_d;

  function automatic logic [CNT_W-1:0] popcount(input logic [NREGS-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt = cnt + {{(CNT_W-1){1'b0}}, v[i]};
    end
    return cnt;
  endfunction

  // Scanning downward lets the lowest set bit win, giving ascending ARM order.
  function automatic logic [RIDX_W-1:0] lowestSet(input logic [NREGS-1:0] v);
    logic [RIDX_W-1:0] enc;
    enc = '0;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (v[i]) begin
        enc = RIDX_W'(i);
      end
    end
    return enc;
  endfunction

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      list_q   <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      regnum_q <= '0;
    end else begin
      state_q  <= state_d;
      list_q   <= list_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      regnum_q <= regnum_d;
    end
  end

  always_comb begin
    list_d  = list_q;
    count_d = count_q;
    idx_d   = idx_q;
    if (LSM_EN) begin
      case (LSM_IN)
        CMD_LOAD: begin
          list_d  = REG_LIST;
          count_d = popcount(REG_LIST);
          idx_d   = '0;
        end
        CMD_NEXT: begin
          if (list_q != '0) begin
            list_d = list_q & (list_q - 1'b1);
            idx_d  = idx_q + 1'b1;
          end
        end
        // COUNT survives an abort so the base writeback offset stays usable.
        CMD_ABORT: begin
          list_d = '0;
          idx_d  = '0;
        end
        default: begin
        end
      endcase
    end

    if (list_d == '0) begin
      state_d = IDLE;
    end else if ((list_d & (list_d - 1'b1)) == '0) begin
      state_d = LAST;
    end else begin
      state_d = RUN;
    end
    regnum_d = lowestSet(list_d);
  end

  assign LSM_DETECT = (state_q != IDLE);
  assign LSM_END    = (state_q == LAST);
  assign REG_NUM    = regnum_q;
  assign IDX        = idx_q;
  assign BEAT_OFF   = {idx_q, 2'b00};
  assign WB_OFF     = {count_q, 2'b00};

endmodule

// File: tb/tb_lsm_sequencer.sv
// Self-checking bench for lsm_sequencer: a set-based model of the remaining
// register list is compared against the DUT every cycle, plus pinned literals.
module tb_lsm_sequencer;

  logic        CLK;
  logic        RESET;
  logic        LSM_EN;
  logic [2:0]  LSM_IN;
  logic [15:0] REG_LIST;
  logic        LSM_DETECT;
  logic        LSM_END;
  logic [3:0]  REG_NUM;
  logic [4:0]  IDX;
  logic [6:0]  BEAT_OFF;
  logic [6:0]  WB_OFF;

  int nChecks = 0;
  int nErrors = 0;
  bit checkEn = 0;

  logic [15:0] mList;
  int          mCount;
  int          mIdx;

  lsm_sequencer #(.NREGS(16), .RIDX_W(4), .CNT_W(5)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .LSM_EN(LSM_EN),
    .LSM_IN(LSM_IN),
    .REG_LIST(REG_LIST),
    .LSM_DETECT(LSM_DETECT),
    .LSM_END(LSM_END),
    .REG_NUM(REG_NUM),
    .IDX(IDX),
    .BEAT_OFF(BEAT_OFF),
    .WB_OFF(WB_OFF)
  );

  initial CLK = 0;
  always #5 CLK = ~CLK;

  function automatic int lowestOf(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Model: the remaining list is a set of registers; NEXT removes the smallest.
  always @(posedge CLK) begin
    if (RESET) begin
      mList = 16'h0; mCount = 0; mIdx = 0;
    end else if (LSM_EN) begin
      case (LSM_IN)
        3'b001: begin mList = REG_LIST; mCount = $countones(REG_LIST); mIdx = 0; end
        3'b010: if (mList != 0) begin mList[lowestOf(mList)] = 1'b0; mIdx = mIdx + 1; end
        3'b011: begin mList = 16'h0; mIdx = 0; end
        default: ;
      endcase
    end
  end

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (checkEn) begin
      checkVal("model.detect", 32'(LSM_DETECT), 32'(mList != 0));
      checkVal("model.end",    32'(LSM_END),    32'($countones(mList) == 1));
      checkVal("model.regnum", 32'(REG_NUM),    32'(lowestOf(mList)));
      checkVal("model.idx",    32'(IDX),        32'(mIdx));
      checkVal("model.beat",   32'(BEAT_OFF),   32'(mIdx * 4));
      checkVal("model.wb",     32'(WB_OFF),     32'(mCount * 4));
    end
  end

  task automatic applyStimulus(input logic en, input logic [2:0] cmd, input logic [15:0] list);
    LSM_EN = en; LSM_IN = cmd; REG_LIST = list;
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int det, input int endv, input int rn,
                             input int idx, input int beat, input int wb);
    if (det  >= 0) checkVal({tag, ".detect"}, 32'(LSM_DETECT), 32'(det));
    if (endv >= 0) checkVal({tag, ".end"},    32'(LSM_END),    32'(endv));
    if (rn   >= 0) checkVal({tag, ".regnum"}, 32'(REG_NUM),    32'(rn));
    if (idx  >= 0) checkVal({tag, ".idx"},    32'(IDX),        32'(idx));
    if (beat >= 0) checkVal({tag, ".beat"},   32'(BEAT_OFF),   32'(beat));
    if (wb   >= 0) checkVal({tag, ".wb"},     32'(WB_OFF),     32'(wb));
  endtask

  initial begin
    RESET = 1; LSM_EN = 1; LSM_IN = 3'b001; REG_LIST = 16'hFFFF;
    applyStimulus(1, 3'b001, 16'hFFFF);
    applyStimulus(1, 3'b001, 16'hFFFF);
    checkEn = 1;
    checkOutput("reset", 0, 0, 0, 0, 0, 0);
    RESET = 0;

    applyStimulus(1, 3'b001, 16'h8005);
    checkOutput("load8005", 1, 0, 0, 0, 0, 12);
    applyStimulus(1, 3'b010, 16'h0);
    checkOutput("next1", 1, 0, 2, 1, 4, 12);
    applyStimulus(1, 3'b010, 16'h0);
    checkOutput("next2", 1, 1, 15, 2, 8, 12);
    applyStimulus(1, 3'b010, 16'h0);
    checkOutput("next3", 0, 0, 0, 3, 12, 12);
    applyStimulus(1, 3'b010, 16'h0);
    checkOutput("next4", 0, 0, 0, 3, 12, 12);

    applyStimulus(1, 3'b001, 16'h0000);
    checkOutput("loadEmpty", 0, 0, 0, 0, 0, 0);

    applyStimulus(1, 3'b001, 16'h0010);
    checkOutput("loadSingle", 1, 1, 4, 0, 0, 4);

    applyStimulus(1, 3'b001, 16'hFFFF);
    checkOutput("loadFull", 1, 0, 0, 0, 0, 64);
    for (int i = 1; i <= 15; i++) begin
      applyStimulus(1, 3'b010, 16'h0);
      checkOutput("fullNext", 1, (i == 15) ? 1 : 0, i, i, i * 4, 64);
    end
    checkOutput("fullLast", 1, 1, 15, 15, 60, 64);

    applyStimulus(1, 3'b001, 16'h00F0);
    applyStimulus(1, 3'b010, 16'h0);
    applyStimulus(1, 3'b011, 16'h0);
    checkOutput("abort", 0, 0, 0, 0, 0, 16);

    applyStimulus(1, 3'b001, 16'h00F0);
    applyStimulus(1, 3'b010, 16'h0);
    applyStimulus(1, 3'b001, 16'h0003);
    checkOutput("reload", 1, 0, 0, 0, 0, 8);

    applyStimulus(1, 3'b001, 16'h00F0);
    applyStimulus(1, 3'b010, 16'h0);
    applyStimulus(0, 3'b010, 16'h0);
    applyStimulus(0, 3'b010, 16'h0);
    checkOutput("hold", 1, 0, 5, 1, 4, 16);

    applyStimulus(1, 3'b110, 16'h1234);
    checkOutput("reserved", 1, 0, 5, 1, 4, 16);

    RESET = 1;
    applyStimulus(1, 3'b010, 16'h0);
    checkOutput("midReset", 0, 0, 0, 0, 0, 0);
    RESET = 0;

    for (int n = 0; n < 400; n++) begin
      logic [15:0] lst;
      logic [2:0]  cmd;
      lst = 16'($urandom);
      if ($urandom_range(0, 3) == 0) lst = lst & 16'($urandom) & 16'($urandom);
      cmd = ($urandom_range(0, 9) < 6) ? 3'b010 : 3'($urandom_range(0, 7));
      RESET = ($urandom_range(0, 39) == 0);
      applyStimulus($urandom_range(0, 7) != 0, cmd, lst);
    end
    RESET = 0;
    applyStimulus(0, 3'b000, 16'h0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

// File: doc/lsm_sequencer.md
Name: lsm_sequencer

Overview:
- Register-list sequencer for ARM LDM/STM (load/store multiple) instructions.
- Sits beside the microprogrammed control unit and is driven by its LSM_EN and LSM_IN2..LSM_IN0 control-word bits.
- Returns LSM_DETECT and LSM_END as the control unit's next-state condition inputs.
- Supplies the register-file index and the transfer offsets for each beat of the multiple transfer.

Parameters:
- NREGS, 16, width of the register list (IR[15:0]); must be a power of two.
- RIDX_W, 4, width of the register index, equal to log2(NREGS).
- CNT_W, 5, width of the transfer count/index (holds 0..NREGS).

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- LSM_EN  input  1  command strobe from the control word.
- LSM_IN  input  3  command code (control word LSM_IN2..LSM_IN0).
- REG_LIST  input  NREGS  register list, taken from IR[15:0].
- LSM_DETECT  output  1  1 = at least one register remains to transfer.
- LSM_END  output  1  1 = exactly one register remains (current beat is the last).
- REG_NUM  output  RIDX_W  index of the lowest set bit of the remaining list; 0 when the list is empty.
- IDX  output  CNT_W  beats completed since LOAD.
- BEAT_OFF  output  CNT_W+2  IDX*4, the byte offset of the current beat.
- WB_OFF  output  CNT_W+2  COUNT*4, the base-writeback byte offset.

Behaviour:
- Reset and sampling
  - The reset is synchronous and active-high, on CLK.
  - RESET=1 at an edge sets: internal list 0, COUNT 0, IDX 0, state IDLE.
  - As a result, LSM_DETECT=0, LSM_END=0, REG_NUM=0, BEAT_OFF=0, WB_OFF=0.
  - RESET has priority over every command, including mid-sequence.
- Commands are sampled only when LSM_EN=1.
  - 000 NOP.
  - 001 LOAD.
  - 010 NEXT.
  - 011 ABORT.
  - 1xx reserved; treated as NOP.
  - LSM_EN=0 means hold.
- LOAD
  - list <= REG_LIST.
  - COUNT <= popcount(REG_LIST).
  - IDX <= 0.
  - Accepted in any state; a LOAD while RUN or LAST restarts the sequence.
- NEXT
  - If the list is nonzero: clear the lowest set bit and IDX <= IDX+1.
  - If the list is empty: no-op, and IDX does not increment.
- ABORT
  - list <= 0, IDX <= 0.
  - COUNT is retained, so WB_OFF stays valid for writeback.
- FSM state is derived from the next list value.
  - IDLE: list = 0.
  - RUN: two or more bits set.
  - LAST: exactly one bit set.
- Transitions:
  - IDLE -LOAD-> IDLE, RUN or LAST, according to the popcount of REG_LIST.
  - RUN -NEXT-> RUN or LAST.
  - LAST -NEXT-> IDLE.
  - Any state -ABORT-> IDLE.
- Output decoding:
  - LSM_DETECT = (state != IDLE).
  - LSM_END = (state == LAST).
- Registered outputs: REG_NUM, IDX, LSM_DETECT and LSM_END are registered.
  - Each is valid in the cycle after the sampling edge.
  - Latency from command to output is 1 cycle.
- Combinational outputs: BEAT_OFF and WB_OFF are combinational shifts of the registered IDX and COUNT.
- Priority encoding: REG_NUM is a lowest-index-first priority encode, which gives the ARM ascending-register order.
- Width rules:
  - COUNT reaches 16 for list 0xFFFF, so CNT_W=5 is mandatory.
  - WB_OFF maximum is 64 (7 bits).
  - No wrap-around is possible; IDX never exceeds COUNT.
- Empty list on LOAD (REG_LIST=0):
  - COUNT=0, state IDLE, LSM_DETECT=0.
  - The control unit then skips the transfer loop.
- Single-register list: LOAD goes directly to LAST (LSM_END=1 after 1 cycle).
- RESET mid-sequence: all outputs are 0 on the next cycle, and COUNT is cleared.

Test Plan:
- Reset after RESET=1 for 2 cycles, with LSM_EN=1, LSM_IN=001 and REG_LIST=0xFFFF also held:
  - All outputs 0; RESET beats LOAD.
- LOAD 0x8005, then NEXT three times:
  - After LOAD: REG_NUM=0, LSM_DETECT=1, LSM_END=0, WB_OFF=12.
  - After NEXT 1: REG_NUM=2, IDX=1, BEAT_OFF=4.
  - After NEXT 2: REG_NUM=15, IDX=2, LSM_END=1.
  - After NEXT 3: LSM_DETECT=0, LSM_END=0, REG_NUM=0, IDX=3.
  - A fourth NEXT leaves IDX=3.
- LOAD 0x0000:
  - LSM_DETECT=0, LSM_END=0, COUNT/WB_OFF=0.
- LOAD 0x0010:
  - One cycle later: LSM_END=1, LSM_DETECT=1, REG_NUM=4, WB_OFF=4.
- LOAD 0xFFFF, then NEXT 15 times:
  - WB_OFF=64 throughout.
  - LSM_END rises exactly after the 15th NEXT, with REG_NUM=15 and BEAT_OFF=60.
- LOAD 0x00F0, NEXT, then ABORT:
  - After ABORT: LSM_DETECT=0, IDX=0, WB_OFF=16 retained.
- LOAD 0x00F0, NEXT, then LOAD 0x0003:
  - After the second LOAD: REG_NUM=0, IDX=0, WB_OFF=8.
- LOAD 0x00F0, NEXT, then hold LSM_EN=0 with LSM_IN=010:
  - No state change.
